// File: rtl/nn_fixed_pkg.sv
// Shared signed fixed-point definitions for the activation datapath.
// Width, unity and rounding-offset helpers are functions so parameterised blocks can derive their own.
package nn_fixed_pkg;

  function automatic int fixed_width(input int int_bits, input int frac_bits);
    return 1 + int_bits + frac_bits;
  endfunction

  function automatic int fixed_one(input int frac_bits);
    return 1 << frac_bits;
  endfunction

  function automatic int fixed_round_ofs(input int frac_bits);
    return 1 << (frac_bits - 1);
  endfunction

  localparam int DEF_INT_BITS  = 7;
  localparam int DEF_FRAC_BITS = 8;
  localparam int W             = fixed_width(DEF_INT_BITS, DEF_FRAC_BITS);
  localparam int ONE           = fixed_one(DEF_FRAC_BITS);
  localparam int ROUND_OFS     = fixed_round_ofs(DEF_FRAC_BITS);

  typedef logic signed [W-1:0] fixed_t;

endpackage

// File: rtl/round_shift_half_up.sv
// Signed right shift with round-half-up (toward +inf) rounding.
// One guard bit on the sum keeps the offset addition from overflowing.
module round_shift_half_up
  import nn_fixed_pkg::*;
#(
  parameter int IN_W  = 25,
  parameter int SHIFT = 8,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [IN_W:0] OFS = (IN_W+1)'(fixed_round_ofs(SHIFT));

  logic signed [IN_W:0] sum_s;

  // add half an LSB of the result, then arithmetic shift
  always_comb begin
    sum_s = $signed({din[IN_W-1], din}) + OFS;
    dout  = OUT_W'(sum_s >>> SHIFT);
  end

endmodule

// File: rtl/sigmoid_backward.sv
// Sigmoid backward pass: dx = g * y * (1 - y), three-stage valid/ready pipeline
// with full backpressure, last-marker passthrough and an output handshake counter.
module sigmoid_backward
  import nn_fixed_pkg::*;
#(
  parameter int INT_BITS  = DEF_INT_BITS,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [FRAC_BITS:0]                in_y,
  input  logic signed [INT_BITS+FRAC_BITS:0] in_g,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [INT_BITS+FRAC_BITS:0] out_dx,
  output logic                              out_last,
  output logic [15:0]                       out_count
);

  localparam int FW = fixed_width(INT_BITS, FRAC_BITS);
  localparam int YW = FRAC_BITS + 1;
  localparam int DW = 2 * YW;
  localparam int SW = FRAC_BITS + 1;
  localparam int PW = FW + FRAC_BITS + 1;
  localparam logic [YW-1:0] Y_ONE = YW'(fixed_one(FRAC_BITS));

  logic [YW-1:0]          y_c_s, y_om_s;
  logic [DW-1:0]          d_s;
  logic signed [SW-1:0]   s_s;
  logic signed [FW-1:0]   dx_s;
  logic                   ld1_s, ld2_s, ld3_s;

  logic                   v1_q, v1_d, l1_q, l1_d;
  logic signed [SW-1:0]   s1_q, s1_d;
  logic signed [FW-1:0]   g1_q, g1_d;
  logic                   v2_q, v2_d, l2_q, l2_d;
  logic signed [PW-1:0]   p2_q, p2_d;
  logic                   v3_q, v3_d, l3_q, l3_d;
  logic signed [FW-1:0]   dx3_q, dx3_d;
  logic [15:0]            cnt_q, cnt_d;

  // stage-1 derivative: clamp y to 1.0 so out-of-range inputs give zero slope
  always_comb begin
    if (in_y > Y_ONE) begin
      y_c_s = Y_ONE;
    end else begin
      y_c_s = in_y;
    end
    y_om_s = Y_ONE - y_c_s;
    d_s    = DW'(y_c_s) * DW'(y_om_s);
  end

  round_shift_half_up #(
    .IN_W  (DW + 1),
    .SHIFT (FRAC_BITS),
    .OUT_W (SW)
  ) u_round_s (
    .din  ($signed({1'b0, d_s})),
    .dout (s_s)
  );

  // |s| <= 0.25, so the rounded product always fits back into FW bits
  round_shift_half_up #(
    .IN_W  (PW),
    .SHIFT (FRAC_BITS),
    .OUT_W (FW)
  ) u_round_dx (
    .din  (p2_q),
    .dout (dx_s)
  );

  // valid/ready chaining and per-stage next state; a stage loads when empty or draining
  always_comb begin
    ld3_s = !v3_q || out_ready;
    ld2_s = !v2_q || ld3_s;
    ld1_s = !v1_q || ld2_s;

    v1_d = v1_q; s1_d = s1_q; g1_d = g1_q; l1_d = l1_q;
    v2_d = v2_q; p2_d = p2_q; l2_d = l2_q;
    v3_d = v3_q; dx3_d = dx3_q; l3_d = l3_q;
    cnt_d = cnt_q;

    if (ld1_s) begin
      v1_d = in_valid;
      if (in_valid) begin
        s1_d = s_s;
        g1_d = in_g;
        l1_d = in_last;
      end else begin
        s1_d = s1_q;
      end
    end else begin
      v1_d = v1_q;
    end

    if (ld2_s) begin
      v2_d = v1_q;
      if (v1_q) begin
        p2_d = PW'(g1_q) * PW'(s1_q);
        l2_d = l1_q;
      end else begin
        p2_d = p2_q;
      end
    end else begin
      v2_d = v2_q;
    end

    if (ld3_s) begin
      v3_d = v2_q;
      if (v2_q) begin
        dx3_d = dx_s;
        l3_d  = l2_q;
      end else begin
        dx3_d = dx3_q;
      end
    end else begin
      v3_d = v3_q;
    end

    if (v3_q && out_ready) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // pipeline and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      s1_q  <= '0;
      g1_q  <= '0;
      l1_q  <= 1'b0;
      v2_q  <= 1'b0;
      p2_q  <= '0;
      l2_q  <= 1'b0;
      v3_q  <= 1'b0;
      dx3_q <= '0;
      l3_q  <= 1'b0;
      cnt_q <= 16'd0;
    end else begin
      v1_q  <= v1_d;
      s1_q  <= s1_d;
      g1_q  <= g1_d;
      l1_q  <= l1_d;
      v2_q  <= v2_d;
      p2_q  <= p2_d;
      l2_q  <= l2_d;
      v3_q  <= v3_d;
      dx3_q <= dx3_d;
      l3_q  <= l3_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_ready  = ld1_s;
  assign out_valid = v3_q;
  assign out_dx    = dx3_q;
  assign out_last  = l3_q;
  assign out_count = cnt_q;

endmodule
